// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Initiator side of the ALU enable/done handshake. Takes one
//                operation per valid/ready request and drives the multi-cycle
//                ALU. It captures result, flags and HI/LO when the ALU
//                reports done, then presents a response to the consumer.
//  Options     : ALU_TIMEOUT_EN - aborts a WAIT that exceeds TIMEOUT_CYCLES
//  Revision    : 1.0  initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    // request channel
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    // response channel
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_overflow,
    output logic        rsp_err,
    // architectural HI/LO
    output logic [31:0] hi_q,
    output logic [31:0] lo_q,
    // ALU side
    output logic        alu_en,
    output logic [3:0]  alu_control,
    output logic [31:0] alu_srcA,
    output logic [31:0] alu_srcB,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_hi,
    input  logic [31:0] alu_lo,
    input  logic        alu_overflow,
    input  logic        alu_zero,
    input  logic        alu_done
);

    localparam logic [3:0] OP_MULT = 4'd8;
    localparam logic [3:0] OP_DIV  = 4'd9;
    localparam logic [3:0] OP_LAST = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic accept;
    logic op_illegal;
    logic done_hit;
    logic timeout_hit;

    // An op is rejected up front when it is undefined or a divide by zero;
    // such ops never reach the ALU.
    assign accept     = (state == S_IDLE) && req_valid;
    assign op_illegal = (req_op > OP_LAST) || ((req_op == OP_DIV) && (req_b == 32'd0));
    assign done_hit   = (state == S_WAIT) && alu_en && alu_done;

`ifdef ALU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Abort once TIMEOUT_CYCLES WAIT cycles have elapsed without done;
    // a done on the limiting edge takes priority.
    assign timeout_hit = (state == S_WAIT) && !alu_done &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // WAIT cycle counter, restarted on every accepted request
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if ((state == S_WAIT) && (wait_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    next_state = op_illegal ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (done_hit || timeout_hit) begin
                    next_state = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Operand capture, ALU enable, response capture and HI/LO update
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_en       <= 1'b0;
            alu_control  <= 4'd0;
            alu_srcA     <= 32'd0;
            alu_srcB     <= 32'd0;
            rsp_result   <= 32'd0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_err      <= 1'b0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
        end else begin
            if (accept) begin
                alu_control  <= req_op;
                alu_srcA     <= req_a;
                alu_srcB     <= req_b;
                alu_en       <= !op_illegal;
                rsp_result   <= 32'd0;
                rsp_zero     <= 1'b0;
                rsp_overflow <= 1'b0;
                rsp_err      <= op_illegal;
            end
            if (done_hit) begin
                alu_en       <= 1'b0;
                rsp_result   <= alu_result;
                rsp_zero     <= alu_zero;
                rsp_overflow <= alu_overflow;
                if ((alu_control == OP_MULT) || (alu_control == OP_DIV)) begin
                    hi_q <= alu_hi;
                    lo_q <= alu_lo;
                end
            end else if (timeout_hit) begin
                alu_en     <= 1'b0;
                rsp_result <= 32'd0;
                rsp_err    <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
